// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Package     : servo_pkg
// Description : Constants, helpers and FSM state type shared by the servo PWM
//               generator and decoder.
// Contents    : SERVO_MAX_ANGLE, ANGLE_W, default pulse-width limits,
//               us_to_clks(), servo_state_t.
// Revision    : 1.0 - initial release
// ============================================================================
package servo_pkg;

  localparam int unsigned SERVO_MAX_ANGLE  = 180;
  localparam int unsigned ANGLE_W          = 8;
  localparam int unsigned DEF_MIN_PULSE_US = 1000;
  localparam int unsigned DEF_MAX_PULSE_US = 2000;

  // Whole-microsecond clock rate first, so the product stays exact for any
  // clock that is an integer number of MHz.
  function automatic int unsigned us_to_clks(input int unsigned clk_freq,
                                             input int unsigned us);
    logic [63:0] prod;
    prod = (64'(clk_freq) / 64'd1_000_000) * 64'(us);
    return prod[31:0];
  endfunction

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } servo_state_t;

endpackage
`default_nettype wire

// File: rtl/servo_pwm_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : servo_pwm_decoder_if
// Description : PWM pin plus decoded results of the servo PWM decoder.
// Signals     : pwm_in (pin), angle, angle_valid, pulse_clks, pulse_err,
//               signal_lost.
// Modports    : master - PWM source / result consumer
//               slave  - decoder
// Note        : CNT_W must equal $clog2(TIMEOUT_CLKS+1) of the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface servo_pwm_decoder_if #(
  parameter int CNT_W = 22
);
  import servo_pkg::*;

  logic               pwm_in;
  logic [ANGLE_W-1:0] angle;
  logic               angle_valid;
  logic [CNT_W-1:0]   pulse_clks;
  logic               pulse_err;
  logic               signal_lost;

  modport master (
    output pwm_in,
    input  angle, angle_valid, pulse_clks, pulse_err, signal_lost
  );

  modport slave (
    input  pwm_in,
    output angle, angle_valid, pulse_clks, pulse_err, signal_lost
  );

endinterface
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : pwm_edge_sync
// Description : Two-flop synchroniser for the asynchronous PWM pin followed by
//               an edge-detect flop. rise/fall are registered one-cycle pulses
//               with identical latency from the pin.
// Ports       : clk, rst_n (async active-low), din (async pin),
//               rise, fall (one-cycle strobes)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_edge_sync (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  din,
  output logic rise,
  output logic fall
);

  logic       meta;
  logic       sync;
  logic       prev;
  // Fills with ones after reset; edges are reported only once every stage
  // holds a real pin sample, so a pin already high at reset release does not
  // masquerade as a rising edge.
  logic [2:0] primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      prev   <= 1'b0;
      primed <= 3'b000;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      prev   <= sync;
      primed <= {primed[1:0], 1'b1};
      rise   <= primed[2] &  sync & ~prev;
      fall   <= primed[2] & ~sync &  prev;
    end
  end

endmodule
`default_nettype wire

// File: rtl/servo_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : servo_pwm_decoder
// Description : Measures the high time of a servo PWM pulse and recovers the
//               0..180 degree command angle without a divider. Flags pulses
//               outside the tolerated range and loss of signal.
// Ports       : clk, rst_n (async active-low),
//               bus.pwm_in      - asynchronous PWM pin
//               bus.angle       - last accepted angle
//               bus.angle_valid - strobe, angle updated
//               bus.pulse_clks  - high time of last completed pulse
//               bus.pulse_err   - strobe, completed pulse out of range
//               bus.signal_lost - level, set on timeout, cleared on accept
// Revision    : 1.0 - initial release
// ============================================================================
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned MIN_PULSE_US = DEF_MIN_PULSE_US,
  parameter int unsigned MAX_PULSE_US = DEF_MAX_PULSE_US,
  parameter int unsigned TOL_US       = 100,
  parameter int unsigned TIMEOUT_US   = 25_000
) (
  input wire                  clk,
  input wire                  rst_n,
  servo_pwm_decoder_if.slave  bus
);

  localparam int unsigned MIN_CLKS     = us_to_clks(CLK_FREQ, MIN_PULSE_US);
  localparam int unsigned MAX_CLKS     = us_to_clks(CLK_FREQ, MAX_PULSE_US);
  localparam int unsigned TOL_CLKS     = us_to_clks(CLK_FREQ, TOL_US);
  localparam int unsigned TIMEOUT_CLKS = us_to_clks(CLK_FREQ, TIMEOUT_US);
  localparam int unsigned DEG_CLKS     = (MAX_CLKS - MIN_CLKS) / SERVO_MAX_ANGLE;
  localparam int          CNT_W        = $clog2(TIMEOUT_CLKS + 1);
  localparam int          DIV_W        = (DEG_CLKS > 1) ? $clog2(DEG_CLKS) : 1;

  localparam logic [CNT_W-1:0]   C_MIN     = CNT_W'(MIN_CLKS);
  localparam logic [CNT_W-1:0]   C_LO_LIM  = CNT_W'(MIN_CLKS - TOL_CLKS);
  localparam logic [CNT_W-1:0]   C_HI_LIM  = CNT_W'(MAX_CLKS + TOL_CLKS);
  localparam logic [CNT_W-1:0]   C_TMO     = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0]   C_TMO_M1  = CNT_W'(TIMEOUT_CLKS - 1);
  localparam logic [DIV_W-1:0]   C_DIV_TOP = DIV_W'(DEG_CLKS - 1);
  localparam logic [ANGLE_W-1:0] C_MAX_DEG = ANGLE_W'(SERVO_MAX_ANGLE);

  logic rise;
  logic fall;

  pwm_edge_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus.pwm_in),
    .rise  (rise),
    .fall  (fall)
  );

  servo_state_t       state;
  logic [CNT_W-1:0]   hi_cnt;
  logic [CNT_W-1:0]   lo_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [ANGLE_W-1:0] deg_cnt;

  // hi_cnt holds the number of high cycles seen so far (1 after the rise
  // cycle). Whenever hi_cnt >= MIN_CLKS, deg_cnt tracks
  // floor((hi_cnt - MIN_CLKS) / DEG_CLKS) incrementally, with div_cnt as the
  // running remainder, so the angle is ready at the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_WAIT;
      hi_cnt          <= '0;
      lo_cnt          <= '0;
      div_cnt         <= '0;
      deg_cnt         <= '0;
      bus.angle       <= '0;
      bus.angle_valid <= 1'b0;
      bus.pulse_clks  <= '0;
      bus.pulse_err   <= 1'b0;
      bus.signal_lost <= 1'b1;
    end else begin
      bus.angle_valid <= 1'b0;
      bus.pulse_err   <= 1'b0;

      case (state)
        S_WAIT: begin
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= CNT_W'(1);
            lo_cnt  <= '0;
            div_cnt <= '0;
            deg_cnt <= '0;
          end
        end

        S_HIGH: begin
          if (fall) begin
            state          <= S_LOW;
            lo_cnt         <= CNT_W'(1);
            bus.pulse_clks <= hi_cnt;
            if ((hi_cnt >= C_LO_LIM) && (hi_cnt <= C_HI_LIM)) begin
              bus.angle       <= deg_cnt;
              bus.angle_valid <= 1'b1;
              bus.signal_lost <= 1'b0;
            end else begin
              bus.pulse_err   <= 1'b1;
            end
          end else if (hi_cnt >= C_TMO_M1) begin
            // Stuck high: abandon the pulse silently.
            state           <= S_WAIT;
            hi_cnt          <= C_TMO;
            bus.signal_lost <= 1'b1;
          end else begin
            hi_cnt <= hi_cnt + CNT_W'(1);
            if (hi_cnt >= C_MIN) begin
              if (div_cnt == C_DIV_TOP) begin
                div_cnt <= '0;
                if (deg_cnt < C_MAX_DEG) begin
                  deg_cnt <= deg_cnt + ANGLE_W'(1);
                end
              end else begin
                div_cnt <= div_cnt + DIV_W'(1);
              end
            end
          end
        end

        S_LOW: begin
          // A rise takes priority over a simultaneous low timeout.
          if (rise) begin
            state   <= S_HIGH;
            hi_cnt  <= CNT_W'(1);
            div_cnt <= '0;
            deg_cnt <= '0;
          end else if (lo_cnt >= C_TMO_M1) begin
            state           <= S_WAIT;
            lo_cnt          <= C_TMO;
            bus.signal_lost <= 1'b1;
          end else begin
            lo_cnt <= lo_cnt + CNT_W'(1);
          end
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
`default_nettype wire
